// File: rtl/uart_collector_if.sv
// Byte stream handshake between uart_collector and its consumer.
// Carries tdata/tlast/tvalid/tready with AXI-Stream transfer rules.
interface uart_collector_if;
    logic [7:0] tdata;
    logic       tlast;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/uart_collector.sv
// 8N1 UART receiver that reassembles bytes into a first-word-fall-through
// FIFO and presents them as a byte stream, with sticky overflow/framing flags.
module uart_collector #(
    parameter int         CLKS_PER_BIT = 139,
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [7:0] LAST_CHAR    = 8'h0A
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_uart_rx,
    uart_collector_if.master  axis,
    output logic              o_overflow,
    output logic              o_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FULL_XOR  = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          rx_meta, rx_s, rx_prev;
    logic [7:0]    shift;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [8:0]    head;
    logic          full, empty, stop_good, push, pop;

    assign full      = (wr_ptr ^ rd_ptr) == FULL_XOR;
    assign empty     = (wr_ptr == rd_ptr);
    // A good stop sample is the only push source; a full FIFO drops it even if popped now.
    assign stop_good = (state == STOP) && (cnt == BIT_LAST) && rx_s;
    assign push      = stop_good && !full;
    assign pop       = !empty && axis.tready;

    assign head        = mem[rd_ptr[AW-1:0]];
    assign axis.tdata  = head[7:0];
    assign axis.tlast  = head[8];
    assign axis.tvalid = !empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_overflow  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_meta <= i_uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (stop_good && full) o_overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (!rx_s && rx_prev) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        idx <= idx + 1'b1;
                        if (idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bits arrive LSB first, so shift in from the top.
    always_ff @(posedge i_clk) begin
        if (state == DATA && cnt == BIT_LAST) shift <= {rx_s, shift[7:1]};
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {shift == LAST_CHAR, shift};
    end
endmodule
